// File: rtl/count_monitor_pkg.sv
// Shared types, constants and the next-value prediction used by the count monitor.
package count_monitor_pkg;

  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned PRED_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  // Computed on a wide word; callers truncate to the counter width, which keeps the result modulo 2^WIDTH.
  function automatic logic [PRED_W-1:0] predict_next(input logic [PRED_W-1:0] q,
                                                     input logic mode,
                                                     input logic rst);
    if (rst) begin
      return '0;
    end else if (mode) begin
      return q - PRED_W'(1);
    end else begin
      return q + PRED_W'(1);
    end
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Observed counter signals, monitor controls and monitor status bundled as one port.
interface count_monitor_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WRAP_W = 16
);
  import count_monitor_pkg::*;

  logic [WIDTH-1:0]     cnt_q;
  logic                 cnt_mode;
  logic                 cnt_rst;
  logic                 mon_en;
  logic                 err_clr;
  logic [WIDTH-1:0]     threshold;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 wrap_up;
  logic                 wrap_dn;
  logic [WRAP_W-1:0]    wrap_cnt;
  logic                 thr_hit;
  logic [1:0]           state;

  modport master (
    output cnt_q, cnt_mode, cnt_rst, mon_en, err_clr, threshold,
    input  locked, err, err_cnt, wrap_up, wrap_dn, wrap_cnt, thr_hit, state
  );

  modport slave (
    input  cnt_q, cnt_mode, cnt_rst, mon_en, err_clr, threshold,
    output locked, err, err_cnt, wrap_up, wrap_dn, wrap_cnt, thr_hit, state
  );

endinterface

// File: rtl/count_step_checker.sv
// Combinational step check: compares the new counter value with the prediction and flags events.
module count_step_checker
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev_q,
  input  logic             prev_mode,
  input  logic             prev_rst,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic [WIDTH-1:0] threshold,
  output logic             match,
  output logic             wrap_up_det,
  output logic             wrap_dn_det,
  output logic             thr_det
);

  localparam logic [WIDTH-1:0] Q_MAX = '1;

  logic [WIDTH-1:0] exp_q;

  // Counter-reset steps never raise events, so every detector is gated by prev_rst.
  always_comb begin
    exp_q       = WIDTH'(predict_next(PRED_W'(prev_q), prev_mode, prev_rst));
    match       = (cnt_q == exp_q);
    wrap_up_det = !prev_rst && !prev_mode && (prev_q == Q_MAX) && (cnt_q == '0);
    wrap_dn_det = !prev_rst &&  prev_mode && (prev_q == '0)   && (cnt_q == Q_MAX);
    thr_det     = !prev_rst && (cnt_q == threshold) && (prev_q != threshold);
  end

endmodule

// File: rtl/count_monitor.sv
// Up/down counter observer: locks onto a consistent count, flags step faults, reports wraps and threshold arrivals.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WRAP_W = 16,
  parameter int unsigned LOCK_N = 4
) (
  input logic            clk,
  input logic            reset,
  count_monitor_if.slave bus
);

  localparam int unsigned      MCNT_W   = $clog2(LOCK_N + 1);
  localparam logic [MCNT_W-1:0] LOCK_MAX = MCNT_W'(LOCK_N);

  mon_state_e           state_q, state_d;
  logic [MCNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0]     prev_q;
  logic                 prev_mode;
  logic                 prev_rst;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WRAP_W-1:0]    wrap_cnt_q, wrap_cnt_d;
  logic                 wrap_up_q, wrap_up_d;
  logic                 wrap_dn_q, wrap_dn_d;
  logic                 thr_hit_q, thr_hit_d;
  logic                 locked_q;
  logic                 take_events;
  logic                 match, wrap_up_det, wrap_dn_det, thr_det;

  count_step_checker #(.WIDTH(WIDTH)) u_checker (
    .prev_q      (prev_q),
    .prev_mode   (prev_mode),
    .prev_rst    (prev_rst),
    .cnt_q       (bus.cnt_q),
    .threshold   (bus.threshold),
    .match       (match),
    .wrap_up_det (wrap_up_det),
    .wrap_dn_det (wrap_dn_det),
    .thr_det     (thr_det)
  );

  // Next-state and next-output logic; err_clr and a dropped enable override any step result.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    thr_hit_d   = 1'b0;
    take_events = 1'b0;

    if (bus.err_clr || !bus.mon_en) begin
      state_d = IDLE;
      if (bus.err_clr) err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = ACQUIRE;
          match_cnt_d = '0;
        end
        ACQUIRE: begin
          if (match) begin
            take_events = 1'b1;
            match_cnt_d = match_cnt_q + MCNT_W'(1);
            if (match_cnt_d == LOCK_MAX) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            take_events = 1'b1;
          end else begin
            state_d = FAULT;
            err_d   = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (take_events) begin
      wrap_up_d = wrap_up_det;
      wrap_dn_d = wrap_dn_det;
      thr_hit_d = thr_det;
      if ((wrap_up_det || wrap_dn_det) && (wrap_cnt_q != '1)) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      match_cnt_q <= '0;
      prev_q      <= '0;
      prev_mode   <= 1'b0;
      prev_rst    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
      thr_hit_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      thr_hit_q   <= thr_hit_d;
      locked_q    <= (state_d == LOCKED);
      if (bus.mon_en) begin
        prev_q    <= bus.cnt_q;
        prev_mode <= bus.cnt_mode;
        prev_rst  <= bus.cnt_rst;
      end
    end
  end

  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.wrap_up  = wrap_up_q;
  assign bus.wrap_dn  = wrap_dn_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.thr_hit  = thr_hit_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed scenarios then random traffic, all checked against an arithmetic reference model.
module tb_count_monitor;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned WRAP_W = 16;
  localparam int unsigned LOCK_N = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  count_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .LOCK_N(LOCK_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model (state: 0 idle, 1 acquire, 2 locked, 3 fault)
  int m_state, m_cnt, m_errcnt, m_wrapcnt;
  bit m_err, m_wu, m_wd, m_thr;
  int p_q;
  bit p_mode, p_rst;

  // Stimulus-side counter
  int cq;
  bit cmode, crst;
  int hits;
  int r;

  function automatic void model_step();
    int q, thr, exp_q;
    bit match, ev;
    q   = int'(bus.cnt_q);
    thr = int'(bus.threshold);
    if (reset) begin
      m_state = 0; m_cnt = 0; m_errcnt = 0; m_wrapcnt = 0;
      m_err = 0; m_wu = 0; m_wd = 0; m_thr = 0;
      p_q = 0; p_mode = 0; p_rst = 0;
      return;
    end
    exp_q = p_rst ? 0 : (p_mode ? (p_q + 255) % 256 : (p_q + 1) % 256);
    match = (q == exp_q);
    ev = 0;
    m_wu = 0; m_wd = 0; m_thr = 0;
    if (bus.err_clr || !bus.mon_en) begin
      m_state = 0;
      if (bus.err_clr) m_err = 0;
    end else if (m_state == 0) begin
      m_state = 1;
      m_cnt = 0;
    end else if (m_state == 1) begin
      if (match) begin
        ev = 1;
        m_cnt++;
        if (m_cnt == int'(LOCK_N)) m_state = 2;
      end else begin
        m_cnt = 0;
      end
    end else if (m_state == 2) begin
      if (match) ev = 1;
      else begin
        m_state = 3;
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
    if (ev && !p_rst) begin
      m_wu  = !p_mode && p_q == 255 && q == 0;
      m_wd  =  p_mode && p_q == 0   && q == 255;
      m_thr = (q == thr) && (p_q != thr);
      if ((m_wu || m_wd) && m_wrapcnt < 65535) m_wrapcnt++;
    end
    if (bus.mon_en) begin
      p_q = q; p_mode = bus.cnt_mode; p_rst = bus.cnt_rst;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state",    32'(bus.state),    32'(m_state));
    chk("locked",   32'(bus.locked),   32'(m_state == 2));
    chk("err",      32'(bus.err),      32'(m_err));
    chk("err_cnt",  32'(bus.err_cnt),  32'(m_errcnt));
    chk("wrap_up",  32'(bus.wrap_up),  32'(m_wu));
    chk("wrap_dn",  32'(bus.wrap_dn),  32'(m_wd));
    chk("wrap_cnt", 32'(bus.wrap_cnt), 32'(m_wrapcnt));
    chk("thr_hit",  32'(bus.thr_hit),  32'(m_thr));
  endtask

  // Present the stimulus counter for one cycle, then advance it as a real counter would.
  task automatic cyc();
    bus.cnt_q    = WIDTH'(cq);
    bus.cnt_mode = cmode;
    bus.cnt_rst  = crst;
    tick();
    cq   = crst ? 0 : (cmode ? (cq + 255) % 256 : (cq + 1) % 256);
    crst = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.cnt_q = '0; bus.cnt_mode = 1'b0; bus.cnt_rst = 1'b0;
    bus.mon_en = 1'b0; bus.err_clr = 1'b0; bus.threshold = 8'd200;
    cq = 0; cmode = 0; crst = 0; hits = 0;

    cyc(); cyc();
    chk("reset_state", 32'(bus.state), 32'd0);

    // Acquire and lock counting up from 0
    reset = 1'b0;
    bus.mon_en = 1'b1;
    cyc();
    chk("enter_acquire", 32'(bus.state), 32'd1);
    repeat (3) cyc();
    chk("not_locked_yet", 32'(bus.locked), 32'd0);
    cyc();
    chk("lock_state", 32'(bus.state), 32'd2);
    chk("lock_flag", 32'(bus.locked), 32'd1);
    chk("lock_no_err", 32'(bus.err), 32'd0);

    // Up wrap 254, 255, 0
    while (cq != 255) cyc();
    cyc();
    chk("pre_wrap_up", 32'(bus.wrap_up), 32'd0);
    cyc();
    chk("wrap_up_pulse", 32'(bus.wrap_up), 32'd1);
    chk("wrap_cnt_1", 32'(bus.wrap_cnt), 32'd1);
    cyc();
    chk("wrap_up_one_cycle", 32'(bus.wrap_up), 32'd0);

    // Down wrap 1, 0, 255
    cmode = 1;
    while (cq != 0) cyc();
    cyc();
    cyc();
    chk("wrap_dn_pulse", 32'(bus.wrap_dn), 32'd1);
    chk("wrap_cnt_2", 32'(bus.wrap_cnt), 32'd2);
    cyc();
    chk("wrap_dn_one_cycle", 32'(bus.wrap_dn), 32'd0);

    // Step fault 10 -> 12
    cmode = 0;
    while (cq != 10) cyc();
    cyc();
    cq = 12;
    cyc();
    chk("fault_state", 32'(bus.state), 32'd3);
    chk("fault_err", 32'(bus.err), 32'd1);
    chk("fault_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("fault_unlocked", 32'(bus.locked), 32'd0);
    cq = 40;
    cyc();
    chk("fault_no_recount", 32'(bus.err_cnt), 32'd1);
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    chk("clr_idle", 32'(bus.state), 32'd0);
    chk("clr_err", 32'(bus.err), 32'd0);
    chk("clr_keeps_cnt", 32'(bus.err_cnt), 32'd1);

    // Threshold arrival at 5
    bus.threshold = 8'd5;
    cq = 0; cmode = 0;
    cyc();
    repeat (8) begin
      cyc();
      if (bus.thr_hit === 1'b1) hits++;
    end
    chk("thr_single_pulse", 32'(hits), 32'd1);

    // Counter reset at 255 in up mode, threshold 0
    bus.threshold = 8'd0;
    while (cq != 255) cyc();
    crst = 1;
    cyc();
    cyc();
    chk("rst_no_wrap", 32'(bus.wrap_up), 32'd0);
    chk("rst_no_thr", 32'(bus.thr_hit), 32'd0);
    chk("rst_still_locked", 32'(bus.state), 32'd2);
    cyc();

    // Enable drop for one cycle, then re-lock
    bus.mon_en = 1'b0;
    cyc();
    chk("dis_idle", 32'(bus.state), 32'd0);
    chk("dis_unlocked", 32'(bus.locked), 32'd0);
    chk("dis_wrap_kept", 32'(bus.wrap_cnt), 32'd3);
    chk("dis_errcnt_kept", 32'(bus.err_cnt), 32'd1);
    bus.mon_en = 1'b1;
    repeat (LOCK_N) cyc();
    chk("relock_acquiring", 32'(bus.state), 32'd1);
    cyc();
    chk("relock_done", 32'(bus.state), 32'd2);

    // Random traffic: glitches, counter resets, mode flips, clears, enable drops, block resets
    repeat (800) begin
      r = int'($urandom_range(0, 199));
      if (r < 6)       cq = int'($urandom_range(0, 255));
      else if (r < 14) crst = 1;
      else if (r < 22) cmode = ~cmode;
      bus.err_clr = ($urandom_range(0, 39) == 0);
      bus.mon_en  = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 29) == 0) bus.threshold = WIDTH'($urandom_range(0, 255));
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
